// File: rtl/bus_host_arbiter_2_if.sv
// Bundle for the two host request ports, the shared bus-hub port, and the grant/timeout status.
// The slave modport is the arbiter. The master modport is the environment that drives the hosts and the hub.
interface bus_host_arbiter_2_if;
    logic [31:0] host0_address;
    logic [31:0] host0_data_write;
    logic [3:0]  host0_write_mask;
    logic        host0_ren;
    logic        host0_wen;
    logic [31:0] host0_data_read;
    logic        host0_ready;

    logic [31:0] host1_address;
    logic [31:0] host1_data_write;
    logic [3:0]  host1_write_mask;
    logic        host1_ren;
    logic        host1_wen;
    logic [31:0] host1_data_read;
    logic        host1_ready;

    logic [31:0] device_address;
    logic [31:0] device_data_write;
    logic [3:0]  device_write_mask;
    logic        device_ren;
    logic        device_wen;
    logic [31:0] device_data_read;
    logic        device_ready;

    logic [1:0]  grant;
    logic        timeout_err;

    modport slave (
        input  host0_address, host0_data_write, host0_write_mask, host0_ren, host0_wen,
        input  host1_address, host1_data_write, host1_write_mask, host1_ren, host1_wen,
        input  device_data_read, device_ready,
        output host0_data_read, host0_ready, host1_data_read, host1_ready,
        output device_address, device_data_write, device_write_mask, device_ren, device_wen,
        output grant, timeout_err
    );

    modport master (
        output host0_address, host0_data_write, host0_write_mask, host0_ren, host0_wen,
        output host1_address, host1_data_write, host1_write_mask, host1_ren, host1_wen,
        output device_data_read, device_ready,
        input  host0_data_read, host0_ready, host1_data_read, host1_ready,
        input  device_address, device_data_write, device_write_mask, device_ren, device_wen,
        input  grant, timeout_err
    );
endinterface

// File: rtl/bus_host_arbiter_2.sv
// Two-host arbiter for a single shared bus hub. It grants the bus with alternating priority and can force-complete a stalled transaction.
// The grant is registered. The granted host's request passes combinationally through to the device.
module bus_host_arbiter_2 #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input logic                 clk,
    input logic                 rst,
    bus_host_arbiter_2_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    localparam logic [15:0] TIMEOUT_L  = TIMEOUT[15:0];
    localparam logic        TIMEOUT_EN = (TIMEOUT != 0);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;  // 1: host1 owned the bus most recently
    logic [15:0] wait_cnt_q, wait_cnt_d;

    logic        req0, req1, granted, owner1;
    logic        own_ren, own_wen, own_req, fwd_ren;
    logic [31:0] own_addr, own_wdata;
    logic [3:0]  own_mask;
    logic        timeout_hit, done;

    assign req0      = bus.host0_ren | bus.host0_wen;
    assign req1      = bus.host1_ren | bus.host1_wen;
    assign granted   = (state_q != IDLE);
    assign owner1    = (state_q == GRANT1);
    assign own_ren   = owner1 ? bus.host1_ren : bus.host0_ren;
    assign own_wen   = owner1 ? bus.host1_wen : bus.host0_wen;
    assign own_addr  = owner1 ? bus.host1_address : bus.host0_address;
    assign own_wdata = owner1 ? bus.host1_data_write : bus.host0_data_write;
    assign own_mask  = owner1 ? bus.host1_write_mask : bus.host0_write_mask;
    assign own_req   = granted & (own_ren | own_wen);
    assign fwd_ren   = own_ren & ~own_wen;

    // A device_ready in the timeout cycle takes precedence and completes the transaction normally.
    assign timeout_hit = TIMEOUT_EN & own_req & ~bus.device_ready & (wait_cnt_q == TIMEOUT_L);
    assign done        = own_req & (bus.device_ready | timeout_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (req0 && req1)
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                else if (req0)
                    state_d = GRANT0;
                else if (req1)
                    state_d = GRANT1;
            end
            GRANT0, GRANT1: begin
                // An abandoned request also counts as a turn for fairness.
                if (!own_req || done) begin
                    state_d      = IDLE;
                    last_grant_d = owner1;
                end else if (wait_cnt_q != 16'hFFFF) begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.device_address    = '0;
        bus.device_data_write = '0;
        bus.device_write_mask = '0;
        bus.device_ren        = 1'b0;
        bus.device_wen        = 1'b0;
        bus.host0_data_read   = '0;
        bus.host0_ready       = 1'b0;
        bus.host1_data_read   = '0;
        bus.host1_ready       = 1'b0;
        bus.grant             = {owner1, state_q == GRANT0};
        bus.timeout_err       = timeout_hit;
        if (granted) begin
            bus.device_address    = own_addr;
            bus.device_data_write = own_wdata;
            bus.device_write_mask = own_mask;
            bus.device_ren        = fwd_ren;
            bus.device_wen        = own_wen;
            if (owner1) begin
                bus.host1_ready     = done;
                bus.host1_data_read = fwd_ren ? (timeout_hit ? ERR_DATA : bus.device_data_read) : '0;
            end else begin
                bus.host0_ready     = done;
                bus.host0_data_read = fwd_ren ? (timeout_hit ? ERR_DATA : bus.device_data_read) : '0;
            end
        end
    end
endmodule

// File: tb/tb_bus_host_arbiter_2.sv
// Bench for bus_host_arbiter_2. Two random host agents and a device model run against scoreboard queues, followed by directed corner sequences.
module tb_bus_host_arbiter_2;
    localparam int          TO   = 4;
    localparam logic [31:0] ERR  = 32'hDEADBEEF;
    localparam logic [31:0] KEY  = 32'h5A5AA5A5;
    localparam int          NTX  = 30;
    localparam int          LMAX = 11;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        ren;
        logic        wen;
    } hreq_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        wr;
        logic [31:0] exp_data;
        logic        exp_to;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          rnd_mode = 1'b1;
    bit          dev_auto = 1'b1;
    bit          sb_en    = 1'b0;
    bit          rnd_go   = 1'b0;
    hreq_t       hd0 = '0, hd1 = '0, h0, h1;
    logic        dd_rdy = 1'b0, dm_rdy = 1'b0;
    logic [31:0] dd_data = '0, dm_data = '0;
    txn_t        q0[$], q1[$];

    bus_host_arbiter_2_if bif();

    bus_host_arbiter_2 #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    assign h0 = rnd_mode ? g_host[0].r : hd0;
    assign h1 = rnd_mode ? g_host[1].r : hd1;
    assign bif.host0_address    = h0.addr;
    assign bif.host0_data_write = h0.wdata;
    assign bif.host0_write_mask = h0.mask;
    assign bif.host0_ren        = h0.ren;
    assign bif.host0_wen        = h0.wen;
    assign bif.host1_address    = h1.addr;
    assign bif.host1_data_write = h1.wdata;
    assign bif.host1_write_mask = h1.mask;
    assign bif.host1_ren        = h1.ren;
    assign bif.host1_wen        = h1.wen;
    assign bif.device_ready     = dev_auto ? dm_rdy : dd_rdy;
    assign bif.device_data_read = dev_auto ? dm_data : dd_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Device model: addresses with bit 31 set are unmapped and never answer. Mapped ones answer after 0..3 extra cycles with addr^KEY.
    initial begin
        int cnt = 0;
        int lat = 0;
        forever begin
            @(posedge clk);
            #2;
            if (dm_rdy) begin
                dm_rdy = 1'b0;
                cnt = 0;
            end else if (bif.device_ren || bif.device_wen) begin
                if (cnt == 0) lat = int'($urandom_range(0, 3));
                if (!bif.device_address[31] && cnt == lat) begin
                    dm_rdy  = 1'b1;
                    dm_data = bif.device_address ^ KEY;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_host
        hreq_t r = '0;
        bit    fin = 1'b0;
        logic  rdy;
        assign rdy = (g == 0) ? bif.host0_ready : bif.host1_ready;

        initial begin
            wait (rnd_go);
            for (int i = 0; i < NTX; i++) begin
                txn_t t;
                int   gap;
                int   kind;
                int   lat;
                gap = int'($urandom_range(0, 3));
                repeat (gap) tick();
                kind       = int'($urandom_range(0, 2));
                t.addr     = $urandom;
                t.addr[31] = ($urandom_range(0, 7) == 0);
                t.wdata    = $urandom;
                t.mask     = 4'($urandom_range(1, 15));
                t.wr       = (kind != 0);
                t.exp_to   = t.addr[31];
                t.exp_data = t.wr ? 32'h0 : (t.exp_to ? ERR : (t.addr ^ KEY));
                if (g == 0) q0.push_back(t);
                else        q1.push_back(t);
                r.addr  = t.addr;
                r.wdata = t.wdata;
                r.mask  = t.mask;
                r.ren   = (kind != 1);
                r.wen   = (kind != 0);
                lat = 0;
                do begin
                    @(negedge clk);
                    lat++;
                end while (!rdy && lat < LMAX);
                chk($sformatf("h%0d_latency_bound", g), 32'(rdy), 32'h1);
                while (!rdy && lat < 60) begin
                    @(negedge clk);
                    lat++;
                end
                tick();
                r.ren = 1'b0;
                r.wen = 1'b0;
            end
            fin = 1'b1;
        end
    end

    initial begin
        txn_t  t;
        hreq_t e;
        forever begin
            @(negedge clk);
            if (sb_en) begin
                if (bif.device_ready && bif.grant == 2'b01 && q0.size() > 0) begin
                    chk("dev_addr_h0", bif.device_address, q0[0].addr);
                    if (q0[0].wr) chk("dev_mask_h0", 32'(bif.device_write_mask), 32'(q0[0].mask));
                end
                if (bif.device_ready && bif.grant == 2'b10 && q1.size() > 0) begin
                    chk("dev_addr_h1", bif.device_address, q1[0].addr);
                    if (q1[0].wr) chk("dev_wdata_h1", bif.device_data_write, q1[0].wdata);
                end
                if (bif.host0_ready) begin
                    if (q0.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL h0_unexpected_ready actual=1 required=0");
                    end else begin
                        t = q0.pop_front();
                        chk("h0_rdata", bif.host0_data_read, t.exp_data);
                        chk("h0_timeout_err", 32'(bif.timeout_err), 32'(t.exp_to));
                    end
                end
                if (bif.host1_ready) begin
                    if (q1.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL h1_unexpected_ready actual=1 required=0");
                    end else begin
                        t = q1.pop_front();
                        chk("h1_rdata", bif.host1_data_read, t.exp_data);
                        chk("h1_timeout_err", 32'(bif.timeout_err), 32'(t.exp_to));
                    end
                end
            end
            chk("grant_onehot0", 32'($onehot0(bif.grant)), 32'h1);
            if (bif.grant == 2'b01) chk("h1_ready_nonowner", 32'(bif.host1_ready), 32'h0);
            if (bif.grant == 2'b10) chk("h0_ready_nonowner", 32'(bif.host0_ready), 32'h0);
            case (bif.grant)
                2'b01:   e = h0;
                2'b10:   e = h1;
                default: e = '0;
            endcase
            chk("dev_wen_follow", 32'(bif.device_wen), 32'(e.wen));
            chk("dev_ren_follow", 32'(bif.device_ren), 32'(e.ren & ~e.wen));
            chk("dev_addr_follow", bif.device_address, e.addr);
            chk("dev_mask_follow", 32'(bif.device_write_mask), 32'(e.mask));
        end
    end

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(bif.grant), 32'h0);
        chk("rst_dev_ren", 32'(bif.device_ren), 32'h0);
        chk("rst_dev_wen", 32'(bif.device_wen), 32'h0);
        chk("rst_h0_ready", 32'(bif.host0_ready), 32'h0);
        chk("rst_h1_ready", 32'(bif.host1_ready), 32'h0);
        chk("rst_timeout_err", 32'(bif.timeout_err), 32'h0);
        rst = 1'b0;
        sb_en = 1'b1;
        rnd_go = 1'b1;

        cyc = 0;
        while (!(g_host[0].fin && g_host[1].fin) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        chk("random_phase_done", 32'(g_host[0].fin && g_host[1].fin), 32'h1);
        repeat (3) @(posedge clk);
        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);
        sb_en = 1'b0;
        rnd_mode = 1'b0;
        dev_auto = 1'b0;
        repeat (2) tick();

        // Reset while host1 owns the bus, then both hosts write together.
        hd1.ren = 1'b1; hd1.addr = 32'h200;
        tick();
        @(negedge clk); chk("d33_grant_pre", 32'(bif.grant), 32'h2);
        tick();
        dd_rdy = 1'b1; dd_data = 32'h55;
        rst = 1'b1;
        #1;
        chk("d33_grant_rst", 32'(bif.grant), 32'h0);
        chk("d33_dev_ren_rst", 32'(bif.device_ren), 32'h0);
        chk("d33_dev_wen_rst", 32'(bif.device_wen), 32'h0);
        chk("d33_h1_ready_rst", 32'(bif.host1_ready), 32'h0);
        hd0 = '{addr: 32'h300, wdata: 32'hAAAA, mask: 4'hF, ren: 1'b0, wen: 1'b1};
        hd1 = '{addr: 32'h400, wdata: 32'hBBBB, mask: 4'hF, ren: 1'b0, wen: 1'b1};
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("d30_idle_grant", 32'(bif.grant), 32'h0);
        chk("d25_idle_h0_ready", 32'(bif.host0_ready), 32'h0);
        chk("d25_idle_h1_ready", 32'(bif.host1_ready), 32'h0);
        tick();
        @(negedge clk);
        chk("d30_grant_a", 32'(bif.grant), 32'h1);
        chk("d30_h0_ready", 32'(bif.host0_ready), 32'h1);
        chk("d30_h1_ready_g0", 32'(bif.host1_ready), 32'h0);
        tick();
        hd0 = '0;
        @(negedge clk); chk("d30_grant_b", 32'(bif.grant), 32'h0);
        tick();
        @(negedge clk);
        chk("d30_grant_c", 32'(bif.grant), 32'h2);
        chk("d30_h1_ready", 32'(bif.host1_ready), 32'h1);
        tick();
        hd1 = '0; dd_rdy = 1'b0;
        @(negedge clk); chk("d30_grant_d", 32'(bif.grant), 32'h0);

        // host0 read with two wait cycles.
        tick();
        hd0.ren = 1'b1; hd0.addr = 32'h100; dd_data = 32'h12345678;
        @(negedge clk); chk("d29_grant_n", 32'(bif.grant), 32'h0);
        tick();
        @(negedge clk);
        chk("d29_grant_n1", 32'(bif.grant), 32'h1);
        chk("d29_dev_ren", 32'(bif.device_ren), 32'h1);
        chk("d29_dev_addr", bif.device_address, 32'h100);
        tick();
        @(negedge clk); chk("d29_wait_ready", 32'(bif.host0_ready), 32'h0);
        tick();
        dd_rdy = 1'b1;
        @(negedge clk);
        chk("d29_h0_ready", 32'(bif.host0_ready), 32'h1);
        chk("d29_h0_rdata", bif.host0_data_read, 32'h12345678);
        tick();
        dd_rdy = 1'b0; hd0 = '0;
        @(negedge clk);
        chk("d29_idle_grant", 32'(bif.grant), 32'h0);
        chk("d29_idle_ready", 32'(bif.host0_ready), 32'h0);

        // ren and wen together, then the owner abandons while host1 waits.
        tick();
        hd0 = '{addr: 32'h104, wdata: 32'hCAFE0000, mask: 4'b0011, ren: 1'b1, wen: 1'b1};
        dd_data = 32'hFFFFFFFF;
        tick();
        @(negedge clk);
        chk("d32_grant", 32'(bif.grant), 32'h1);
        chk("d32_dev_wen", 32'(bif.device_wen), 32'h1);
        chk("d32_dev_ren", 32'(bif.device_ren), 32'h0);
        chk("d32_mask", 32'(bif.device_write_mask), 32'h3);
        chk("d32_h0_rdata", bif.host0_data_read, 32'h0);
        tick();
        hd0.wen = 1'b0;
        hd1 = '{addr: 32'hF0000000, wdata: 32'h0, mask: 4'h0, ren: 1'b1, wen: 1'b0};
        @(negedge clk); chk("d34_dev_ren_on", 32'(bif.device_ren), 32'h1);
        tick();
        hd0.ren = 1'b0; dd_rdy = 1'b1;
        @(negedge clk);
        chk("d34_dev_ren_drop", 32'(bif.device_ren), 32'h0);
        chk("d34_h0_no_ready", 32'(bif.host0_ready), 32'h0);
        chk("d34_h1_no_ready", 32'(bif.host1_ready), 32'h0);
        tick();
        dd_rdy = 1'b0;
        @(negedge clk); chk("d34_idle", 32'(bif.grant), 32'h0);
        tick();
        @(negedge clk); chk("d34_grant_h1", 32'(bif.grant), 32'h2);

        // host1 read that is never answered.
        for (int k = 0; k < TO; k++) begin
            if (k > 0) begin tick(); @(negedge clk); end
            chk($sformatf("d31_wait%0d_ready", k), 32'(bif.host1_ready), 32'h0);
            chk($sformatf("d31_wait%0d_terr", k), 32'(bif.timeout_err), 32'h0);
        end
        tick();
        @(negedge clk);
        chk("d31_h1_ready", 32'(bif.host1_ready), 32'h1);
        chk("d31_h1_rdata", bif.host1_data_read, ERR);
        chk("d31_terr", 32'(bif.timeout_err), 32'h1);
        tick();
        hd1 = '0;
        @(negedge clk);
        chk("d31_idle", 32'(bif.grant), 32'h0);
        chk("d31_terr_clear", 32'(bif.timeout_err), 32'h0);

        // device_ready in the timeout cycle completes the transaction normally.
        tick();
        hd0 = '{addr: 32'h108, wdata: 32'h0, mask: 4'h0, ren: 1'b1, wen: 1'b0};
        dd_data = 32'h0BADF00D;
        tick();
        @(negedge clk); chk("d23_grant", 32'(bif.grant), 32'h1);
        repeat (TO - 1) tick();
        tick();
        dd_rdy = 1'b1;
        @(negedge clk);
        chk("d23_h0_ready", 32'(bif.host0_ready), 32'h1);
        chk("d23_h0_rdata", bif.host0_data_read, 32'h0BADF00D);
        chk("d23_no_terr", 32'(bif.timeout_err), 32'h0);
        tick();
        dd_rdy = 1'b0; hd0 = '0;
        @(negedge clk); chk("d23_idle", 32'(bif.grant), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_host_arbiter_2.md
BUS_HOST_ARBITER_2 -- requirements
Module: bus_host_arbiter_2

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning device cycles allowed per transaction before forced completion; 0 disables timeout; legal range 0..65535.
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEADBEEF, meaning read data returned on timeout.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports host<n>_address / host<n>_data_write  input  32 each  host n request address/write data (n = 0, 1).
REQ-006 SHALL have port host<n>_write_mask  input  4  byte-enable mask of host n.
REQ-007 SHALL have ports host<n>_ren / host<n>_wen  input  1 each  read/write request of host n.
REQ-008 SHALL have port host<n>_data_read  output  32  read data to host n.
REQ-009 SHALL have port host<n>_ready  output  1  transaction-complete strobe to host n.
REQ-010 SHALL have ports device_address / device_data_write  output  32 each, device_write_mask  output  4, device_ren / device_wen  output  1 each: request to the shared bus hub.
REQ-011 SHALL have ports device_data_read  input  32 and device_ready  input  1: response from the bus hub.
REQ-012 SHALL have port grant  output  2  one-hot current owner (bit n = host n), 0 when idle.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse when a transaction is force-completed.

Function
REQ-014 SHALL implement states IDLE, GRANT0, GRANT1; a host requests when ren|wen is high.
REQ-015 IDLE: one requester -> grant it next cycle; both -> grant host not granted last (last_grant register, reset to host1 so host0 wins first tie); none -> stay IDLE.
REQ-016 grant SHALL be registered: request seen in IDLE at cycle N -> grant and device request visible at N+1.
REQ-017 In GRANTn, device_* request outputs SHALL combinationally follow host n; otherwise all device_* outputs SHALL be 0.
REQ-018 If host n asserts both ren and wen, device_wen=1 and device_ren=0 (write wins).
REQ-019 In GRANTn, host<n>_ready = device_ready and host<n>_data_read = device_data_read (only when device_ren forwarded, else 0); the non-owner sees ready=0, data_read=0.
REQ-020 device_ready in GRANTn SHALL complete the transaction: update last_grant=n, return to IDLE next cycle; no back-to-back grant without one IDLE cycle.
REQ-021 A 16-bit wait counter SHALL clear on entering GRANTn and increment each GRANT cycle without device_ready.
REQ-022 When TIMEOUT!=0 and counter == TIMEOUT with device_ready low, that cycle SHALL assert host<n>_ready=1, host<n>_data_read=ERR_DATA (reads) or 0 (writes), timeout_err=1, then IDLE.
REQ-023 device_ready and timeout in the same cycle: normal completion wins, no timeout_err.
REQ-024 If owner drops ren and wen before ready, SHALL abandon: device request drops same cycle, IDLE next cycle, no ready to any host, last_grant updated.
REQ-025 device_ready while IDLE SHALL be ignored (no host ready).
REQ-026 A non-owner holding a request SHALL wait without loss; starvation bounded to one transaction of the other host.

Reset
REQ-027 On rst: state IDLE, last_grant=host1, counter 0; grant=0, timeout_err=0, all host_ready/data_read and device_* outputs 0, asynchronously.
REQ-028 rst mid-transaction SHALL abort it with no ready pulse; first grant after release follows REQ-015.

Verification
REQ-029 host0 read 0x100, device_ready 2 cycles after grant with data 0x12345678 -> grant=01 at N+1, host0_ready one cycle with 0x12345678, IDLE after.
REQ-030 both hosts write same cycle, ready after 1 cycle each -> grant sequence 01, 00, 10, 00; host1 never sees ready during GRANT0.
REQ-031 TIMEOUT=4, host1 read to unmapped address, device_ready never -> 4 wait cycles then host1_ready=1, data 0xDEADBEEF, timeout_err=1 one cycle.
REQ-032 host0 ren=wen=1 mask 4'b0011 -> device_wen=1, device_ren=0, device_write_mask=0011, host0_data_read=0.
REQ-033 rst pulsed during GRANT1 -> grant=0, device_ren/wen=0 immediately, no ready; after release with both requesting -> grant=01.
REQ-034 host0 drops ren mid-wait -> device_ren low same cycle, IDLE next, pending host1 granted following cycle.
